// File: rtl/mprj_pad_ctrl_pkg.sv
// mprj_pad_ctrl_pkg: shared states, padframe defaults and pad OEN/REN mapping for the MPRJ pad sequencer
package mprj_pad_ctrl_pkg;
   typedef enum logic [2:0] {HOLD, RELEASE, APPLY, RUN, TURN} state_t;
   localparam int NPADS = 38;
   localparam logic [NPADS-1:0] DEFAULT_DIR = 38'h0F_FFC0_0042;
   localparam logic [NPADS-1:0] DEFAULT_PULL = 38'h0;
   localparam logic [NPADS-1:0] INPUT_ONLY_MASK = 38'h10_003F_FF80;
   function automatic logic [1:0] pad_map(input logic dir, input logic pull, input logic in_only);
      return {~(dir & ~in_only), ~pull};
   endfunction
endpackage

// File: rtl/mprj_pad_ctrl_seq.sv
// mprj_pad_ctrl_seq: safe-state hold, serial config and break-before-make OEN/REN sequencing; PAD_CTRL_PARITY_EN adds a parity bit and sticky cfg_err
module mprj_pad_ctrl_seq #(
   parameter int NPADS = mprj_pad_ctrl_pkg::NPADS,
   parameter int HOLD_CYCLES = 16,
   parameter int TURN_CYCLES = 2,
   parameter logic [NPADS-1:0] DEFAULT_DIR = NPADS'(mprj_pad_ctrl_pkg::DEFAULT_DIR),
   parameter logic [NPADS-1:0] DEFAULT_PULL = NPADS'(mprj_pad_ctrl_pkg::DEFAULT_PULL),
   parameter logic [NPADS-1:0] INPUT_ONLY_MASK = NPADS'(mprj_pad_ctrl_pkg::INPUT_ONLY_MASK)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cfg_sdi,
   input  logic             cfg_shift,
   input  logic             cfg_load,
   output logic             cfg_sdo,
   output logic             cfg_busy,
   output logic             pads_ready,
   output logic [NPADS-1:0] pad_oen,
   output logic [NPADS-1:0] pad_ren
`ifdef PAD_CTRL_PARITY_EN
   ,
   output logic             cfg_err
`endif
);
   import mprj_pad_ctrl_pkg::*;
   localparam int CW = 2 * NPADS;
`ifdef PAD_CTRL_PARITY_EN
   localparam int SW = CW + 1;
`else
   localparam int SW = CW;
`endif
   localparam int TW = $clog2(HOLD_CYCLES + TURN_CYCLES);
   state_t state, state_n;
   logic [TW-1:0] cnt, cnt_n;
   logic [SW-1:0] shadow, def_sh;
   logic [CW-1:0] active, active_n, snap, snap_n, def_cfg;
   logic [NPADS-1:0] run_oen, run_ren, chg, oen_n, ren_n;
   logic [1:0] a_m, s_m;
   logic par_ok, busy_n;
   assign cfg_sdo = shadow[0];
`ifdef PAD_CTRL_PARITY_EN
   assign def_sh = {^def_cfg, def_cfg};
   assign par_ok = ~^shadow;
`else
   assign def_sh = def_cfg;
   assign par_ok = 1'b1;
`endif
   // reset configuration, interleaved as {pull, dir} per pad
   always_comb begin
      def_cfg = '0;
      for (int i = 0; i < NPADS; i++) def_cfg[2*i +: 2] = {DEFAULT_PULL[i], DEFAULT_DIR[i]};
   end
   // sequencer: hold, release, apply, then run with a fixed-length turnaround on every accepted load
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      active_n = active;
      snap_n = snap;
      case (state)
         HOLD: if (cnt == TW'(HOLD_CYCLES - 1)) begin state_n = RELEASE; cnt_n = '0; end
         RELEASE: state_n = APPLY;
         APPLY: begin state_n = RUN; active_n = shadow[CW-1:0]; end
         RUN: if (cfg_load && par_ok) begin state_n = TURN; snap_n = shadow[CW-1:0]; cnt_n = '0; end
         TURN: if (cnt == TW'(TURN_CYCLES - 1)) begin state_n = RUN; active_n = snap; end
         default: state_n = HOLD;
      endcase
   end
   // next pad values; during turnaround pads whose effective OEN will change are forced undriven
   always_comb begin
      a_m = '0;
      s_m = '0;
      run_oen = '1;
      run_ren = '1;
      chg = '0;
      for (int i = 0; i < NPADS; i++) begin
         a_m = pad_map(active_n[2*i], active_n[2*i+1], INPUT_ONLY_MASK[i]);
         s_m = pad_map(snap_n[2*i], snap_n[2*i+1], INPUT_ONLY_MASK[i]);
         run_oen[i] = a_m[1];
         run_ren[i] = a_m[0];
         chg[i] = |((a_m ^ s_m) & 2'b10);
      end
      oen_n = state_n == RUN ? run_oen : state_n == TURN ? run_oen | chg : '1;
      ren_n = state_n inside {RUN, TURN} ? run_ren : state_n inside {RELEASE, APPLY} ? '1 : '0;
      busy_n = state_n inside {HOLD, RELEASE, TURN};
   end
   // state, shift chain, configuration and registered pad outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= HOLD;
         cnt <= '0;
         shadow <= def_sh;
         active <= def_cfg;
         snap <= def_cfg;
         pad_oen <= '1;
         pad_ren <= '0;
         cfg_busy <= 1'b1;
         pads_ready <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         shadow <= cfg_shift ? {cfg_sdi, shadow[SW-1:1]} : shadow;
         active <= active_n;
         snap <= snap_n;
         pad_oen <= oen_n;
         pad_ren <= ren_n;
         cfg_busy <= busy_n;
         pads_ready <= state_n == RUN;
      end
   end
`ifdef PAD_CTRL_PARITY_EN
   // sticky flag for a load rejected on bad parity
   always_ff @(posedge wb_clk_i) cfg_err <= wb_rst_i ? 1'b0 : cfg_err | (state == RUN && cfg_load && !par_ok);
`endif
endmodule

// File: tb/tb_mprj_pad_ctrl_seq.sv
// tb_mprj_pad_ctrl_seq: randomized self-checking bench with a cycle-count based reference model
module tb_mprj_pad_ctrl_seq;
   localparam int N = 38, CW = 76, HOLD = 16, TURN = 2, OW = 2 * N + 3;
   localparam logic [N-1:0] DIR0 = 38'h0F_FFC0_0042, PULL0 = 38'h0, MASK = 38'h10_003F_FF80;
`ifdef PAD_CTRL_PARITY_EN
   localparam int SW = CW + 1;
`else
   localparam int SW = CW;
`endif
   logic clk = 1'b0;
   logic rst, cfg_sdi, cfg_shift, cfg_load, cfg_sdo, cfg_busy, pads_ready;
   logic [N-1:0] pad_oen, pad_ren;
   logic [OW-1:0] obs;
   int errors = 0, checks = 0;
   logic [SW-1:0] m_sh;
   logic [CW-1:0] m_act, m_snap;
   int since, turn_left;
   logic m_err;
`ifdef PAD_CTRL_PARITY_EN
   logic cfg_err;
`endif
   assign obs = {pad_oen, pad_ren, cfg_busy, pads_ready, cfg_sdo};
   always #5 clk = ~clk;
   mprj_pad_ctrl_seq dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cfg_sdi(cfg_sdi), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
      .cfg_sdo(cfg_sdo), .cfg_busy(cfg_busy), .pads_ready(pads_ready), .pad_oen(pad_oen), .pad_ren(pad_ren)
`ifdef PAD_CTRL_PARITY_EN
      , .cfg_err(cfg_err)
`endif
   );
   function automatic logic [CW-1:0] mix(input logic [N-1:0] d, input logic [N-1:0] p);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c[2*i] = d[i];
         c[2*i+1] = p[i];
      end
      return c;
   endfunction
   function automatic logic [SW-1:0] seal(input logic [CW-1:0] c);
`ifdef PAD_CTRL_PARITY_EN
      return {^c, c};
`else
      return c;
`endif
   endfunction
   function automatic logic [N-1:0] oen_of(input logic [CW-1:0] c);
      logic [N-1:0] o;
      for (int i = 0; i < N; i++) o[i] = !(c[2*i] && !MASK[i]);
      return o;
   endfunction
   function automatic logic [N-1:0] ren_of(input logic [CW-1:0] c);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = !c[2*i+1];
      return r;
   endfunction
   function automatic logic [CW-1:0] rand_cfg();
      return CW'({$urandom(), $urandom(), $urandom()});
   endfunction
   function automatic logic [OW-1:0] exp_vec();
      logic [N-1:0] o, r;
      logic b, rd;
      o = '1;
      r = '0;
      b = 1'b1;
      rd = 1'b0;
      if (since == HOLD || since == HOLD + 1) begin
         r = '1;
         b = since == HOLD;
      end else if (since > HOLD + 1) begin
         o = oen_of(m_act);
         r = ren_of(m_act);
         if (turn_left > 0) o = o | (oen_of(m_act) ^ oen_of(m_snap));
         b = turn_left > 0;
         rd = !b;
      end
      return {o, r, b, rd, m_sh[0]};
   endfunction
   function automatic void step(input logic r, input logic sdi, input logic sh, input logic ld);
      logic [SW-1:0] pre;
      logic ok;
      if (r) begin
         since = 0;
         turn_left = 0;
         m_sh = seal(mix(DIR0, PULL0));
         m_act = mix(DIR0, PULL0);
         m_snap = m_act;
         m_err = 1'b0;
         return;
      end
      pre = m_sh;
`ifdef PAD_CTRL_PARITY_EN
      ok = !(^pre);
`else
      ok = 1'b1;
`endif
      if (sh) m_sh = {sdi, m_sh[SW-1:1]};
      if (turn_left > 0) begin
         turn_left--;
         if (turn_left == 0) m_act = m_snap;
      end else if (since >= HOLD + 2 && ld) begin
         if (ok) begin
            m_snap = pre[CW-1:0];
            turn_left = TURN;
         end else m_err = 1'b1;
      end
      if (since == HOLD + 1) m_act = pre[CW-1:0];
      if (since < 100000) since++;
   endfunction
   task automatic tick(input logic r, input logic sdi, input logic sh, input logic ld);
      rst = r;
      cfg_sdi = sdi;
      cfg_shift = sh;
      cfg_load = ld;
      @(posedge clk);
      step(r, sdi, sh, ld);
      #1;
   endtask
   task automatic shift_in(input logic [SW-1:0] v);
      for (int i = 0; i < SW; i++) tick(1'b0, v[i], 1'b1, 1'b0);
   endtask
   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs !== {{N{1'b1}}, {N{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got %h want oen=1s ren=0s busy=1 ready=0 sdo=0", obs);
      end
      checks++;
      for (int k = 1; k <= 19; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_seq cyc %0d got %h want %h", k, obs, exp_vec());
         end
         checks++;
         if (k == 15 && pad_ren !== '0) begin
            errors++;
            $display("FAIL hold_ren cyc 15 got %h want 0", pad_ren);
         end
         if (k == 16 && pad_ren !== '1) begin
            errors++;
            $display("FAIL release_ren cyc 16 got %h want all 1", pad_ren);
         end
         if (k == 18 && (pad_oen !== 38'h30_003F_FFBD || pads_ready !== 1'b1)) begin
            errors++;
            $display("FAIL run_default cyc 18 got oen=%h ready=%b want oen=30003fffbd ready=1", pad_oen, pads_ready);
         end
         if (k >= 15 && k <= 18) checks++;
      end
   endtask
   task automatic test_dir_change();
      logic [CW-1:0] c;
      int busy_cnt;
      c = rand_cfg();
      c[2*8] = 1'b1;
      c[2*22] = 1'b0;
      c[2*2] = 1'b0;
      shift_in(seal(c));
      busy_cnt = 0;
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, k == 1);
         busy_cnt += int'(cfg_busy);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL dir_change cyc t+%0d got %h want %h", k, obs, exp_vec());
         end
         if (pad_oen[22] !== 1'b1 || pad_oen[8] !== 1'b1) begin
            errors++;
            $display("FAIL pad22_pad8_oen cyc t+%0d got %b%b want 11", k, pad_oen[22], pad_oen[8]);
         end
         checks += 2;
         if (k == 3) begin
            if (pad_oen !== oen_of(c) || pad_ren !== ren_of(c)) begin
               errors++;
               $display("FAIL dir_change_apply got %h/%h want %h/%h", pad_oen, pad_ren, oen_of(c), ren_of(c));
            end
            checks++;
         end
      end
      if (busy_cnt != 2) begin
         errors++;
         $display("FAIL busy_len got %0d want 2", busy_cnt);
      end
      checks++;
   endtask
   task automatic test_enable_pad2();
      logic [CW-1:0] c;
      c = m_act;
      c[2*2] = 1'b1;
      shift_in(seal(c));
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, k == 1);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL pad2_enable cyc t+%0d got %h want %h", k, obs, exp_vec());
         end
         if (pad_oen[2] !== (k < 3)) begin
            errors++;
            $display("FAIL pad2_oen cyc t+%0d got %b want %b", k, pad_oen[2], k < 3);
         end
         if (pad_oen[1] !== !c[2*1]) begin
            errors++;
            $display("FAIL pad1_glitch cyc t+%0d got %b want %b", k, pad_oen[1], !c[2*1]);
         end
         checks += 3;
      end
   endtask
   task automatic test_load_with_shift();
      logic [CW-1:0] c;
      c = rand_cfg();
      shift_in(seal(c));
      for (int k = 1; k <= 6; k++) begin
         tick(1'b0, 1'($urandom_range(0, 1)), k <= 2, k <= 2);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL load_shift cyc t+%0d got %h want %h", k, obs, exp_vec());
         end
         checks++;
         if (cfg_busy !== (k < 3)) begin
            errors++;
            $display("FAIL second_load_busy cyc t+%0d got %b want %b", k, cfg_busy, k < 3);
         end
         checks++;
         if (k >= 3) begin
            if (pad_oen !== oen_of(c) || pad_ren !== ren_of(c)) begin
               errors++;
               $display("FAIL preshift_cfg cyc t+%0d got %h/%h want %h/%h", k, pad_oen, pad_ren, oen_of(c), ren_of(c));
            end
            checks++;
         end
      end
   endtask
   task automatic test_reset_in_turn();
      shift_in(seal(rand_cfg()));
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs !== {{N{1'b1}}, {N{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_in_turn got %h want oen=1s ren=0s busy=1 ready=0 sdo=0", obs);
      end
      checks++;
      for (int k = 1; k <= HOLD + 2; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rehold cyc %0d got %h want %h", k, obs, exp_vec());
         end
         checks++;
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         tick($urandom_range(0, 249) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d got %h want %h", k, obs, exp_vec());
         end
         checks++;
`ifdef PAD_CTRL_PARITY_EN
         if (cfg_err !== m_err) begin
            errors++;
            $display("FAIL random_err cyc %0d got %b want %b", k, cfg_err, m_err);
         end
         checks++;
`endif
      end
   endtask
`ifdef PAD_CTRL_PARITY_EN
   task automatic test_parity();
      logic [CW-1:0] c;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < HOLD + 2; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      c = rand_cfg();
      c[2*2] = 1'b1;
      shift_in({!(^c), c});
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, k == 1);
         if (pad_oen !== oen_of(mix(DIR0, PULL0)) || cfg_busy !== 1'b0 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_reject cyc t+%0d got oen=%h busy=%b err=%b", k, pad_oen, cfg_busy, cfg_err);
         end
         checks++;
      end
      shift_in(seal(c));
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, k == 1);
         if (obs !== exp_vec() || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_reload cyc t+%0d got %h err=%b want %h err=1", k, obs, cfg_err, exp_vec());
         end
         checks++;
         if (k == 3) begin
            if (pad_oen !== oen_of(c)) begin
               errors++;
               $display("FAIL parity_apply got %h want %h", pad_oen, oen_of(c));
            end
            checks++;
         end
      end
   endtask
`endif
   initial begin
      test_reset();
      test_dir_change();
      test_enable_pad2();
      test_load_with_shift();
      test_reset_in_turn();
      test_random();
`ifdef PAD_CTRL_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
